// File: rtl/prbs31_pkg.sv
// prbs31_pkg: shared state type, constants and next-bit prediction for the
// PRBS31 (x^31 + x^28 + 1) generator/checker pair on this die.
package prbs31_pkg;

  localparam int PRBS_LEN = 31;
  localparam int PRBS_TAP = 27;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Next PRBS31 bit from the last 31 bits (sreg[30] is the oldest).
  function automatic logic prbs31_next(input logic [PRBS_LEN-1:0] sreg);
    return sreg[PRBS_LEN-1] ^ sreg[PRBS_TAP];
  endfunction

endpackage

// File: rtl/prbs31_sat_counter.sv
// prbs31_sat_counter: W-bit up counter that sticks at all-ones. A clear on
// the same cycle as an increment leaves the count at 1, not 0.
module prbs31_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] count_reg;

  // Clear first, then let a coincident increment land; saturate at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= inc ? W'(1) : '0;
    end else if (inc && (count_reg != MAX)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/prbs31_checker.sv
// prbs31_checker: self-synchronising bit-serial PRBS31 checker. Fills its
// shift register from the stream, verifies LOCK_LEN predictions, then counts
// errors while locked and drops lock when LOSS_THRESH errors land inside one
// LOSS_WIN-bit window. Build macro PRBS31_CHK_BITCNT_EN adds bit_count, the
// number of valid bits seen while locked.
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int LOCK_LEN    = 32,
  parameter int LOSS_WIN    = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             lol_sticky
`ifdef PRBS31_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int FILL_W = $clog2(PRBS_LEN) + 1;
  localparam int VCNT_W = $clog2(LOCK_LEN) + 1;
  localparam int WCNT_W = $clog2(LOSS_WIN) + 1;
  localparam int WERR_W = $clog2(LOSS_THRESH) + 1;

  state_t              state_reg, state_next;
  logic                locked_reg;
  logic [PRBS_LEN-1:0] sreg_reg, sreg_next, sreg_shift;
  logic [FILL_W-1:0]   fill_reg, fill_next, fill_inc;
  logic [VCNT_W-1:0]   vcnt_reg, vcnt_next;
  logic [WCNT_W-1:0]   win_cnt_reg, win_cnt_next;
  logic [WERR_W-1:0]   win_err_reg, win_err_next;
  logic                err_pulse_reg, lol_reg;
  logic                pred, mismatch, err, loss;

  // Prediction, shift-in value and error/loss decisions for the current bit.
  // While locked the predicted bit is shifted in so one bad bit stays one error.
  always_comb begin
    pred       = prbs31_next(sreg_reg);
    mismatch   = din ^ pred;
    sreg_shift = {sreg_reg[PRBS_LEN-2:0], (state_reg == LOCKED) ? pred : din};
    fill_inc   = (fill_reg == FILL_W'(PRBS_LEN)) ? fill_reg : fill_reg + FILL_W'(1);
    err        = din_valid && (state_reg == LOCKED) && mismatch;
    loss       = err && (win_err_reg == WERR_W'(LOSS_THRESH - 1));
  end

  // Next state: every transition is qualified by a valid input bit.
  always_comb begin
    state_next = state_reg;
    if (din_valid) begin
      case (state_reg)
        SEARCH: if ((fill_inc == FILL_W'(PRBS_LEN)) && (sreg_shift != '0)) state_next = VERIFY;
        VERIFY: begin
          if (mismatch) state_next = SEARCH;
          else if (vcnt_reg == VCNT_W'(LOCK_LEN - 1)) state_next = LOCKED;
        end
        LOCKED: if (loss) state_next = SEARCH;
        default: state_next = SEARCH;
      endcase
    end
  end

  // State register plus a registered copy of the LOCKED decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= SEARCH;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      locked_reg <= (state_next == LOCKED);
    end
  end

  // Shift register and fill/verify/window counters for the current bit.
  always_comb begin
    sreg_next    = sreg_reg;
    fill_next    = fill_reg;
    vcnt_next    = vcnt_reg;
    win_cnt_next = win_cnt_reg;
    win_err_next = win_err_reg;
    if (din_valid) begin
      sreg_next = sreg_shift;
      case (state_reg)
        SEARCH: fill_next = fill_inc;
        VERIFY: begin
          if (mismatch || (vcnt_reg == VCNT_W'(LOCK_LEN - 1))) begin
            vcnt_next = '0;
            if (mismatch) fill_next = '0;
          end else begin
            vcnt_next = vcnt_reg + VCNT_W'(1);
          end
        end
        LOCKED: begin
          if (loss) begin
            fill_next    = '0;
            vcnt_next    = '0;
            win_cnt_next = '0;
            win_err_next = '0;
          end else if (win_cnt_reg == WCNT_W'(LOSS_WIN - 1)) begin
            win_cnt_next = '0;
            win_err_next = '0;
          end else begin
            win_cnt_next = win_cnt_reg + WCNT_W'(1);
            win_err_next = win_err_reg + WERR_W'(err);
          end
        end
        default: fill_next = '0;
      endcase
    end
  end

  // Datapath registers, error strobe and sticky loss-of-lock (clear, then set).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_reg      <= '0;
      fill_reg      <= '0;
      vcnt_reg      <= '0;
      win_cnt_reg   <= '0;
      win_err_reg   <= '0;
      err_pulse_reg <= 1'b0;
      lol_reg       <= 1'b0;
    end else begin
      sreg_reg      <= sreg_next;
      fill_reg      <= fill_next;
      vcnt_reg      <= vcnt_next;
      win_cnt_reg   <= win_cnt_next;
      win_err_reg   <= win_err_next;
      err_pulse_reg <= err;
      if (clear_cnt) lol_reg <= loss;
      else if (loss) lol_reg <= 1'b1;
    end
  end

  prbs31_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_cnt),
    .inc   (err),
    .count (err_count)
  );

`ifdef PRBS31_CHK_BITCNT_EN
  prbs31_sat_counter #(.W(32)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_cnt),
    .inc   (din_valid && (state_reg == LOCKED)),
    .count (bit_count)
  );
`endif

  assign locked     = locked_reg;
  assign err_pulse  = err_pulse_reg;
  assign lol_sticky = lol_reg;

endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: drives a PRBS31 stream (with injected errors, gaps and
// clears) into a default checker and an ERR_W=4 checker, and compares both
// every cycle against a history-based model of the checker's rules.
module tb_prbs31_checker;

  localparam int LOCK_LEN    = 32;
  localparam int LOSS_WIN    = 64;
  localparam int LOSS_THRESH = 8;
  localparam int M_SEARCH    = 0;
  localparam int M_VERIFY    = 1;
  localparam int M_LOCKED    = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic din_valid = 1'b0, din = 1'b0, clear_cnt = 1'b0;
  logic locked, err_pulse, lol_sticky;
  logic locked_s, err_pulse_s, lol_sticky_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
`ifdef PRBS31_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  prbs31_checker #(.ERR_W(16), .LOCK_LEN(LOCK_LEN), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clear_cnt  (clear_cnt),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .lol_sticky (lol_sticky)
`ifdef PRBS31_CHK_BITCNT_EN
    , .bit_count (bit_count)
`endif
  );

  prbs31_checker #(.ERR_W(4), .LOCK_LEN(LOCK_LEN), .LOSS_WIN(LOSS_WIN), .LOSS_THRESH(LOSS_THRESH)) u_dut_w4 (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .clear_cnt  (clear_cnt),
    .locked     (locked_s),
    .err_pulse  (err_pulse_s),
    .err_count  (err_count_s),
    .lol_sticky (lol_sticky_s)
`ifdef PRBS31_CHK_BITCNT_EN
    , .bit_count (bit_count_s)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // hist holds the reference sequence: received bits while acquiring,
  // predicted bits while locked. Prediction is x[n-31] ^ x[n-28].
  int     m_mode = M_SEARCH, m_fill = 0, m_run = 0, m_wbits = 0, m_werr = 0;
  longint m_errs = 0, m_lbits = 0;
  bit     m_pulse = 1'b0, m_lol = 1'b0;
  bit     hist[$];

  always @(posedge clk or posedge rst) begin : model_step
    bit pred, nz;
    if (rst) begin
      m_mode = M_SEARCH; m_fill = 0; m_run = 0; m_wbits = 0; m_werr = 0;
      m_errs = 0; m_lbits = 0; m_pulse = 1'b0; m_lol = 1'b0;
      hist.delete();
      for (int i = 0; i < 31; i++) hist.push_back(1'b0);
    end else begin
      m_pulse = 1'b0;
      if (clear_cnt) begin
        m_errs = 0; m_lol = 1'b0; m_lbits = 0;
      end
      if (din_valid) begin
        pred = hist[hist.size()-31] ^ hist[hist.size()-28];
        if (m_mode == M_LOCKED) begin
          hist.push_back(pred);
          if (m_lbits < 64'hFFFF_FFFF) m_lbits++;
          m_wbits++;
          if (din != pred) begin
            m_pulse = 1'b1; m_errs++; m_werr++;
          end
          if (m_werr == LOSS_THRESH) begin
            m_mode = M_SEARCH; m_fill = 0; m_lol = 1'b1; m_werr = 0; m_wbits = 0;
          end else if (m_wbits == LOSS_WIN) begin
            m_wbits = 0; m_werr = 0;
          end
        end else begin
          hist.push_back(din);
          if (m_mode == M_SEARCH) begin
            if (m_fill < 31) m_fill++;
            nz = 1'b0;
            for (int i = hist.size() - 31; i < hist.size(); i++) nz |= hist[i];
            if (m_fill == 31 && nz) begin
              m_mode = M_VERIFY; m_run = 0;
            end
          end else if (din == pred) begin
            m_run++;
            if (m_run == LOCK_LEN) begin
              m_mode = M_LOCKED; m_wbits = 0; m_werr = 0;
            end
          end else begin
            m_mode = M_SEARCH; m_fill = 0;
          end
        end
        if (hist.size() > 40) void'(hist.pop_front());
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",       locked,       m_mode == M_LOCKED);
      check("locked_w4",    locked_s,     m_mode == M_LOCKED);
      check("err_pulse",    err_pulse,    m_pulse);
      check("err_count",    err_count,    (m_errs > 65535) ? 65535 : m_errs);
      check("err_count_w4", err_count_s,  (m_errs > 15) ? 15 : m_errs);
      check("lol_sticky",   lol_sticky,   m_lol);
`ifdef PRBS31_CHK_BITCNT_EN
      check("bit_count",    bit_count,    m_lbits);
      check("bit_count_w4", bit_count_s,  m_lbits);
`endif
    end
  end

  // ---------------- stimulus ----------------
  logic [30:0] gen = 31'h7FFF_FFFF;

  task automatic gen_bit(output logic b);
    b   = gen[30] ^ gen[27];
    gen = {gen[29:0], b};
  endtask

  // Apply one cycle of inputs; returns just after the sampling edge.
  task automatic send(input logic v, input logic d, input logic c);
    din_valid = v; din = d; clear_cnt = c;
    @(posedge clk); #1;
  endtask

  // One valid generator bit (optionally inverted), preceded by random idles.
  task automatic tx(input logic flip, input int duty, input logic clr);
    logic b;
    while ($urandom_range(99) >= duty) send(1'b0, 1'($urandom), 1'b0);
    gen_bit(b);
    send(1'b1, b ^ flip, clr);
  endtask

  task automatic wait_lock(input int duty, output int nb);
    nb = 0;
    while (!locked && nb < 300) begin
      tx(1'b0, duty, 1'b0);
      nb++;
    end
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int nb;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked",     locked,     0);
    check("rst_err_pulse",  err_pulse,  0);
    check("rst_err_count",  err_count,  0);
    check("rst_lol_sticky", lol_sticky, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    wait_lock(100, nb);
    $display("[%0t] clean lock after %0d valid bits", $time, nb);
    check("clean_lock_bits", nb, 63);
    for (int i = nb; i < 10000; i++) tx(1'b0, 100, 1'b0);
    check("clean_err_count", err_count, 0);

    tx(1'b1, 100, 1'b0);
    $display("[%0t] single flip injected", $time);
    check("flip_pulse", err_pulse, 1);
    check("flip_count", err_count, 1);
    for (int i = 0; i < 1000; i++) tx(1'b0, 100, 1'b0);
    check("flip_count_after", err_count, 1);
    check("flip_locked", locked, 1);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 99; i++) tx(1'b0, 100, 1'b0);
      tx(1'b1, 100, 1'b0);
    end
    for (int i = 0; i < 10; i++) tx(1'b0, 100, 1'b0);
    check("pre_reset_count", err_count, 5);

    #1 rst = 1'b1;
    #1;
    $display("[%0t] async reset while locked", $time);
    check("async_rst_locked",     locked,     0);
    check("async_rst_err_pulse",  err_pulse,  0);
    check("async_rst_err_count",  err_count,  0);
    check("async_rst_lol_sticky", lol_sticky, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    wait_lock(50, nb);
    $display("[%0t] gapped relock after %0d valid bits", $time, nb);
    check("gapped_relock_bits", nb, 63);

    for (int i = 1; i <= 8; i++) begin
      tx(1'b1, 100, 1'b0);
      if (i == 7) check("burst_locked_after_7", locked, 1);
    end
    $display("[%0t] error burst of 8", $time);
    check("burst_unlocked_after_8", locked, 0);
    check("burst_lol_sticky", lol_sticky, 1);
    check("burst_err_count", err_count, 8);

    wait_lock(100, nb);
    $display("[%0t] relock after burst in %0d valid bits", $time, nb);
    check("burst_relock_bits", nb, 63);

    tx(1'b1, 100, 1'b1);
    $display("[%0t] clear_cnt on error cycle", $time);
    check("clear_on_err", err_count, 1);
    check("clear_on_err_w4", err_count_s, 1);
    check("clear_lol_sticky", lol_sticky, 0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 69; i++) tx(1'b0, 75, 1'b0);
      tx(1'b1, 75, 1'b0);
    end
    $display("[%0t] 20 spaced errors sent", $time);
    check("sat_w4", err_count_s, 15);
    check("sat_w16", err_count, 21);
    check("sat_locked", locked, 1);

    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked) seen = 1'b1;
    end
    $display("[%0t] 500 zero bits sent", $time);
    check("zero_never_locked", seen, 0);

    for (int s = 0; s < 15; s++) begin
      int rate;
      rate = (s % 3 == 0) ? 0 : ((s % 3 == 1) ? 40 : 4);
      for (int i = 0; i < 200; i++) begin
        logic f;
        f = (rate != 0) && ($urandom_range(rate - 1) == 0);
        tx(f, 80, $urandom_range(149) == 0);
      end
      $display("[%0t] random segment %0d (error rate 1/%0d)", $time, s, rate);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
